// File: rtl/aes_encrypt.sv
// rtl/aes_encrypt.sv - iterative AES-128 encryptor, one round step per enabled cycle
// Optional done flag is built only when AES_DONE_EN is defined.
module aes_encrypt #(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic [127:0] key,
  input  logic [127:0] data,
  output logic [127:0] out
`ifdef AES_DONE_EN
  ,
  output logic         done
`endif
);

  localparam logic [3:0] STEP_LAST = 4'(Nr + 1);
  localparam logic [3:0] STEP_DONE = 4'(Nr + 2);

  localparam logic [7:0] RCON [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 4; i++) o[127-32*i -: 32] = sub_word(s[127-32*i -: 32]);
    return o;
  endfunction

  // Byte 4*c+r sits in column c, row r; row r rotates left by r columns.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return o;
  endfunction

  function automatic logic [Nr:0][127:0] expand_key(input logic [127:0] k);
    logic [31:0]             w [4*(Nr+1)];
    logic [31:0]             t;
    logic [Nr:0][127:0]      rk;
    for (int i = 0; i < Nk; i++) w[i] = k[127-32*i -: 32];
    for (int i = Nk; i < 4*(Nr+1); i++) begin
      t = w[i-1];
      if (i % Nk == 0) t = sub_word({t[23:0], t[31:24]}) ^ {RCON[i/Nk-1], 24'h000000};
      w[i] = w[i-Nk] ^ t;
    end
    for (int r = 0; r <= Nr; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return rk;
  endfunction

  logic [127:0]       r_state;
  logic [3:0]         r_step;
  logic [Nr:0][127:0] w_rk;
  logic [3:0]         w_rk_idx;
  logic [127:0]       w_key_sel;
  logic [127:0]       w_sr;
  logic [127:0]       w_mc;
  logic [127:0]       w_next;

  assign w_rk = expand_key(key);
  assign w_sr = shift_rows(sub_bytes(r_state));
  assign w_mc = mix_columns(w_sr);

  always_comb begin
    w_rk_idx = (r_step == 4'd0) ? 4'd0 : r_step - 4'd1;
    if (w_rk_idx > 4'(Nr)) w_rk_idx = 4'(Nr);
    w_key_sel = w_rk[w_rk_idx];
  end

  always_comb begin
    w_next = r_state;
    if (r_step == 4'd0)          w_next = data;
    else if (r_step == 4'd1)     w_next = r_state ^ w_key_sel;
    else if (r_step < STEP_LAST) w_next = w_mc ^ w_key_sel;
    else if (r_step == STEP_LAST) w_next = w_sr ^ w_key_sel;
  end

  // Once the counter reaches STEP_DONE the block is frozen until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= 128'h0;
      r_step  <= 4'd0;
    end else if (enable && r_step != STEP_DONE) begin
      r_state <= w_next;
      r_step  <= r_step + 4'd1;
    end
  end

  assign out = r_state;

`ifdef AES_DONE_EN
  assign done = (r_step == STEP_DONE);
`endif

endmodule

// File: tb/tb_aes_encrypt.sv
// tb/tb_aes_encrypt.sv - directed known-answer bench for aes_encrypt with an expected-value queue
module tb_aes_encrypt;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [127:0] key;
  logic [127:0] data;
  logic [127:0] out;
`ifdef AES_DONE_EN
  logic         done;
`endif

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] D1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] R1 = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] D2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

  always #5 clk = ~clk;

  aes_encrypt dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .key    (key),
    .data   (data),
    .out    (out)
`ifdef AES_DONE_EN
    ,
    .done   (done)
`endif
  );

  typedef struct {
    string        tag;
    logic [127:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic clk_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out();
    exp_t e;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL scoreboard: observed empty queue, required a pending entry");
    end else begin
      e = sb.pop_front();
      assert (out === e.val) else begin
        n_err++;
        $error("FAIL %s: observed %h required %h", e.tag, out, e.val);
      end
    end
  endtask

  task automatic cyc_check(input string tag, input logic [127:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
    clk_edge();
    check_out();
  endtask

  task automatic check_done(input string tag, input logic v);
`ifdef AES_DONE_EN
    n_vec++;
    assert (done === v) else begin
      n_err++;
      $error("FAIL %s: observed %b required %b", tag, done, v);
    end
`endif
  endtask

  initial begin
    rst    = 1'b1;
    enable = 1'b1;
    key    = K1;
    data   = D1;
    cyc_check("reset", 128'h0);
    check_done("reset_done", 1'b0);

    rst    = 1'b0;
    enable = 1'b0;
    cyc_check("idle_hold", 128'h0);

    enable = 1'b1;
    cyc_check("edge1_load", D1);
    cyc_check("edge2_ark0", R1);
    for (int k = 3; k <= 11; k++) clk_edge();
    check_done("done_before_last", 1'b0);
    cyc_check("ct_fips_c1", C1);
    check_done("done_after_last", 1'b1);

    data = ~D1;
    for (int k = 0; k < 5; k++) begin
      cyc_check("hold_after_done", C1);
      check_done("done_held", 1'b1);
    end

    rst = 1'b1;
    cyc_check("reset_after_done", 128'h0);
    check_done("done_cleared", 1'b0);
    rst  = 1'b0;
    data = D1;
    for (int k = 1; k <= 12; k++) begin
      enable = 1'b1;
      if (k == 1)       cyc_check("tog_edge1", D1);
      else if (k == 2)  cyc_check("tog_edge2", R1);
      else if (k == 12) cyc_check("tog_ct", C1);
      else              clk_edge();
      enable = 1'b0;
      if (k == 1)       cyc_check("tog_hold1", D1);
      else if (k == 2)  cyc_check("tog_hold2", R1);
      else if (k == 12) cyc_check("tog_hold_ct", C1);
      else              clk_edge();
    end

    rst    = 1'b1;
    enable = 1'b0;
    cyc_check("reset_before_k2", 128'h0);
    rst    = 1'b0;
    key    = K2;
    data   = D2;
    enable = 1'b1;
    for (int k = 0; k < 6; k++) clk_edge();
    rst = 1'b1;
    cyc_check("abort_reset", 128'h0);
    check_done("abort_done", 1'b0);
    rst = 1'b0;
    cyc_check("k2_edge1", D2);
    for (int k = 2; k <= 11; k++) clk_edge();
    cyc_check("ct_fips_c2", C2);
    check_done("k2_done", 1'b1);

    if (sb.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL scoreboard_drain: observed %0d leftover entries, required 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/aes_encrypt.md
AES_ENCRYPT -- requirements
Module: aes_encrypt

Interface
REQ-001 Parameter Nk, default 4: key length in 32-bit words; only 4 (AES-128) is supported.
REQ-002 Parameter Nr, default 10: number of rounds; only 10 is supported.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 enable  input  1  advance the operation by one step per cycle while high.
REQ-006 key  input  128  cipher key; bits 127:120 are key byte 0 (FIPS-197 order).
REQ-007 data  input  128  plaintext block, same byte order.
REQ-008 out  output  128  state register, driven directly.
REQ-009 done  output  1  high while out holds the final ciphertext (present only under AES_DONE_EN).

Function
REQ-010 Key expansion SHALL be combinational from key and SHALL produce round keys 0..10 per FIPS-197.
- Ops: RotWord, SubWord (S-box), Rcon = 01,02,04,08,10,20,40,80,1b,36.
- Round key 0 equals key.
REQ-011 A 4-bit step counter SHALL control the datapath; counter and state update only on cycles with enable=1.
REQ-012 Step 0 SHALL load state <= data and select round key 0.
REQ-013 Step 1 SHALL apply AddRoundKey: state <= state XOR round key 0.
REQ-014 Steps 2..10 SHALL apply a full round with round key (step-1): SubBytes, ShiftRows, MixColumns over GF(2^8) with polynomial 0x11b, then AddRoundKey.
REQ-015 Step 11 SHALL apply the last round (no MixColumns) with round key 10.
REQ-016 The counter SHALL increment each enabled cycle and saturate at 12; at 12 the state holds.
REQ-017 Latency SHALL be 12 enabled rising edges from reset release; out equals the ciphertext after the 12th.
REQ-018 With enable=0, state and counter SHALL hold their values.
REQ-019 data and key SHALL be sampled as follows:
- data is sampled only at step 0.
- key must stay stable through step 11; a change mid-operation corrupts the result and is not detected.
REQ-020 After completion the block SHALL ignore enable until rst; a new encryption requires a reset.
REQ-021 The S-box SHALL be a 256-entry constant table; the same table serves SubBytes and SubWord.

Reset
REQ-022 When rst=1 at a rising edge, state SHALL become 0, the counter 0 and done 0, regardless of enable.
REQ-023 A reset asserted mid-operation SHALL abort the operation; the next enabled cycle is step 0.

Configuration
REQ-024 AES_DONE_EN defined: the done port exists and is 1 exactly when counter = 12. Undefined: the done port and its logic are absent, and out behaviour is identical.

Verification
REQ-025 Reset, then enable=1, key=000102030405060708090a0b0c0d0e0f, data=00112233445566778899aabbccddeeff.
- After edge 12: out=69c4e0d86a7b0430d8cdb78070b4c55a and done=1.
REQ-026 Key 2b7e151628aed2a6abf7158809cf4f3c, data 3243f6a8885a308d313198a2e0370734.
- After edge 12: out=3925841d02dc09fbdc118597196a0b32.
REQ-027 Using the REQ-025 vectors, check intermediates:
- After edge 1: out=data.
- After edge 2: out=00102030405060708090a0b0c0d0e0f0.
- Round key 10 = 13111d7fe3944a17f307a78b4d2b30c5.
REQ-028 REQ-025 vectors with enable toggled 1/0 every cycle: the same ciphertext appears after 12 enabled edges and the state is unchanged on disabled cycles.
REQ-029 Assert rst at step 6, then rerun REQ-026: out=0 after the reset edge, then the correct ciphertext after 12 further enabled edges.
REQ-030 After done, change data and hold enable=1 for 5 cycles: out stays at the ciphertext.
